// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between NUM_REQ byte-stream
// requesters. Round-robin arbitration with packet locking; each byte is
// sequenced as LOAD -> START (tx_start pulse) -> wait tx_busy rise -> wait
// tx_busy fall. A missing tx_busy rise raises timeout_err and retries the byte.
// Optional feature macro: UART_ARB_ID_HEADER_EN -- when defined, each packet
// is preceded by an unacknowledged header byte {4'hA, grant_id}.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [3:0]           grant_id,
  output logic                 locked,
  output logic                 timeout_err
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);
  localparam logic [7:0] CntMax = 8'(BUSY_TIMEOUT - 1);

`ifdef UART_ARB_ID_HEADER_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      grant_q, grant_d;
  logic            locked_q, locked_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic            last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  // Set while the current byte in flight is the packet header.
  logic            hdr_q, hdr_d;

  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;
  logic [7:0]      data_arr [NUM_REQ];

  assign gnt_idx = grant_q[IdxW-1:0];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_arr[g] = req_data[8*g +: 8];
  end

  function automatic logic [IdxW-1:0] wrap_idx(input int unsigned v);
    int unsigned m;
    m = v % NUM_REQ;
    return m[IdxW-1:0];
  endfunction

  // Round-robin pick: first asserted request at or above the pointer, with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && req[wrap_idx(32'(rr_q) + i)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(32'(rr_q) + i);
      end
    end
  end

  // Next-state and output decode of the byte sequencer.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    locked_d    = locked_q;
    rr_d        = rr_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    hdr_d       = hdr_q;
    ack         = '0;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A foreign transmission holds off any grant or restart.
        if (!tx_busy) begin
          if (locked_q) begin
            if (req[gnt_idx]) state_d = StLoad;
          end else if (pick_valid) begin
            grant_d  = 4'(pick_idx);
            locked_d = 1'b1;
            hdr_d    = HdrEn;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        if (hdr_q) begin
          data_d = {4'hA, grant_q};
        end else begin
          data_d = data_arr[gnt_idx];
          last_d = req_last[gnt_idx];
        end
        state_d = StStart;
      end
      StStart: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          if (!hdr_q) ack[gnt_idx] = 1'b1;
          state_d = StWaitDone;
        end else if (cnt_q == CntMax) begin
          // Keep the lock so the same byte (or header) is retried.
          timeout_err = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (hdr_q) begin
            hdr_d = 1'b0;
          end else if (last_q) begin
            locked_d = 1'b0;
            rr_d     = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset drops any in-flight byte without acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      locked_q <= 1'b0;
      rr_q     <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      data_q   <= 8'h00;
      hdr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
      rr_q     <= rr_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      hdr_q    <= hdr_d;
    end
  end

  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester and serializer models drive
// the DUT, expected bytes/acks are queued by the stimulus, and a monitor pops
// and compares them whenever the DUT presents tx_start, ack or timeout_err.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;
`ifdef UART_ARB_ID_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req, req_last, ack;
  logic [8*NR-1:0] req_data;
  logic            tx_start, tx_busy, locked, timeout_err;
  logic [7:0]      tx_data;
  logic [3:0]      grant_id;
  logic            model_busy = 1'b0;
  logic            foreign_busy = 1'b0;

  assign tx_busy = model_busy | foreign_busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .ack        (ack),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .locked     (locked),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_to = 0;
  int skip = 0;
  int last_start = 0;
  int t_req = 0;

  logic [8:0]  rq [NR][$];     // per-requester {last, data}
  logic [7:0]  exp_tx [$];     // bytes the serializer must see, in order
  logic [11:0] exp_ack [$];    // {id, byte} for each expected ack
  logic [8:0]  drv_h;
  logic [11:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  task automatic exp_hdr(input int id);
    if (HDR) exp_tx.push_back({4'hA, 4'(id)});
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic last);
    rq[id].push_back({last, d});
    exp_tx.push_back(d);
    exp_ack.push_back({4'(id), d});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_tx.delete();
    exp_ack.delete();
    exp_to = 0;
    skip   = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Waits for all queued traffic to finish, then checks the lock has dropped.
  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_ack.size() == 0 && exp_to == 0 && !tx_busy) done = 1'b1;
    end
    if (!done) fail({name, "_drain_timeout"});
    repeat (3) @(negedge clk);
    chk({name, "_locked_clear"}, 32'(locked), 0);
  endtask

  // Requester model: present queue heads, retire a byte on its ack.
  initial begin
    req = '0;
    req_data = '0;
    req_last = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() > 0) begin
          drv_h = rq[i][0];
          req[i] = 1'b1;
          req_data[8*i +: 8] = drv_h[7:0];
          req_last[i] = drv_h[8];
        end else begin
          req[i] = 1'b0;
        end
      end
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
    end
  end

  // Serializer model: busy rises one cycle after tx_start and lasts 3 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && rst_n) begin
        if (skip > 0) begin
          skip--;
        end else begin
          @(posedge clk);
          #1 model_busy = 1'b1;
          repeat (3) @(posedge clk);
          #1 model_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every DUT-presented event against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start) begin
          last_start = cyc;
          chk("start_while_busy", 32'(tx_busy), 0);
          if (exp_tx.size() == 0) fail("tx_start_unexpected");
          else chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        if (ack != '0) begin
          chk("ack_onehot", 32'($onehot(ack)), 1);
          if (exp_ack.size() == 0) begin
            fail("ack_unexpected");
          end else begin
            mon_e = exp_ack.pop_front();
            chk("ack_id", 32'(ack), 32'(1) << mon_e[11:8]);
            chk("ack_byte", 32'(tx_data), 32'(mon_e[7:0]));
          end
        end
        if (timeout_err) begin
          chk("timeout_latency", 32'(cyc - last_start), TO);
          if (exp_to == 0) fail("timeout_unexpected");
          else exp_to--;
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single byte from requester 0; tx_start two cycles after req is seen
    @(negedge clk);
    exp_hdr(0);
    send(0, 8'h55, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req[0]) begin seen = 1'b1; t_req = cyc; end
    end
    if (!seen) fail("single_req_timeout");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
    if (!seen) fail("single_start_timeout");
    chk("single_latency", 32'(cyc - t_req), 2);
    chk("single_locked", 32'(locked), 1);
    chk("single_grant", 32'(grant_id), 0);
    wait_drain("single");

    // Pointer is now 1: simultaneous req 0 and 1 must serve 1 first
    @(negedge clk);
    exp_hdr(1);
    send(1, 8'h6B, 1'b1);
    exp_hdr(0);
    send(0, 8'h6A, 1'b1);
    wait_drain("ptr1");

    // Round-robin from pointer 0 with wrap 3 -> 0
    do_reset();
    @(negedge clk);
    exp_hdr(0); send(0, 8'h10, 1'b1);
    exp_hdr(1); send(1, 8'h21, 1'b1);
    exp_hdr(2); send(2, 8'h32, 1'b1);
    exp_hdr(3); send(3, 8'h43, 1'b1);
    exp_hdr(0); send(0, 8'h14, 1'b1);
    wait_drain("rr");

    // Packet lock: requester 2's packet is not interrupted by requester 1
    do_reset();
    @(negedge clk);
    exp_hdr(2);
    send(2, 8'h11, 1'b0);
    send(2, 8'h22, 1'b0);
    send(2, 8'h33, 1'b1);
    repeat (3) @(negedge clk);
    exp_hdr(1);
    send(1, 8'h77, 1'b1);
    wait_drain("lock");

    // Timeout: first attempt gets no busy, then retried and acked
    do_reset();
    @(negedge clk);
    skip   = 1;
    exp_to = 1;
    exp_hdr(1);
    exp_tx.push_back(HDR ? 8'hA1 : 8'h5A);
    send(1, 8'h5A, 1'b1);
    wait_drain("timeout");

    // Foreign transmission in progress: no grant until tx_busy falls
    do_reset();
    @(negedge clk);
    foreign_busy = 1'b1;
    exp_hdr(2);
    send(2, 8'h9C, 1'b1);
    repeat (6) @(negedge clk);
    chk("foreign_no_lock", 32'(locked), 0);
    foreign_busy = 1'b0;
    wait_drain("foreign");

    // Reset during WAIT_DONE, then requester 3 alone must be granted
    do_reset();
    @(negedge clk);
    exp_hdr(2);
    send(2, 8'hB1, 1'b0);
    rq[2].push_back({1'b1, 8'hB2});
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (ack[2]) seen = 1'b1;
    end
    if (!seen) fail("midrst_ack_timeout");
    @(posedge clk);
    #2 rst_n = 1'b0;
    rq[2].delete();
    #1;
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_grant", 32'(grant_id), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_tx_start", 32'(tx_start), 0);
    chk("midrst_ack", 32'(ack), 0);
    @(negedge clk);
    exp_hdr(3);
    send(3, 8'hD3, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (locked) seen = 1'b1;
    end
    if (!seen) fail("midrst_lock_timeout");
    chk("midrst_grant3", 32'(grant_id), 3);
    wait_drain("midrst");

    chk("end_exp_tx_empty", 32'(exp_tx.size()), 0);
    chk("end_exp_ack_empty", 32'(exp_ack.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
